// File: rtl/see_scheduler.sv
// Fault-injection campaign controller: paced, round-robin one-hot upsets per group.
// Ports: s_clk_i/s_resetn_i, start/abort, campaign config, ready in; req, upset, busy/done, stats out.
module see_scheduler #(
  parameter int G   = 4,
  parameter int W   = 32,
  parameter int CW  = 16,
  parameter int TMO = 64
) (
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  input  logic            s_start_i,
  input  logic            s_abort_i,
  input  logic [CW-1:0]   s_period_i,
  input  logic [CW-1:0]   s_count_i,
  input  logic [G-1:0]    s_mask_i,
  input  logic [15:0]     s_seed_i,
  input  logic [G-1:0]    s_ready_i,
  output logic [G-1:0]    s_req_o,
  output logic [G*W-1:0]  s_upset_o,
  output logic            s_busy_o,
  output logic            s_done_o,
  output logic [CW-1:0]   s_injected_o,
  output logic [CW-1:0]   s_dropped_o
);

  localparam int LW = $clog2(W);
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int TW = $clog2(TMO + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_FIRE = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);

  logic [2:0]    state;
  logic [CW-1:0] period_q;
  logic [CW-1:0] remaining;
  logic [G-1:0]  mask_q;
  logic [15:0]   lfsr;
  logic [GW-1:0] last_grp;
  logic [GW-1:0] grp;
  logic [CW-1:0] timer;
  logic [TW-1:0] tmo_cnt;
  logic [CW-1:0] injected;
  logic [CW-1:0] dropped;

  logic [GW-1:0] next_grp;
  logic [CW-1:0] reload;
  logic          last_evt;
  logic          tmo_hit;
  logic [15:0]   lfsr_nxt;

  // Round-robin: first enabled group strictly after the last one served.
  always_comb begin
    logic          found;
    logic [GW-1:0] cand;
    next_grp = last_grp;
    found    = 1'b0;
    for (int i = 1; i <= G; i++) begin
      cand = GW'((int'(last_grp) + i) % G);
      if (!found && mask_q[cand]) begin
        next_grp = cand;
        found    = 1'b1;
      end
    end
  end

  // A zero period still spends one cycle in WAIT.
  assign reload   = (period_q == '0) ? CW'(1) : period_q;
  assign last_evt = (remaining == CW'(1));
  assign tmo_hit  = ((tmo_cnt + TW'(1)) == TW'(TMO));
  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      state     <= S_IDLE;
      period_q  <= '0;
      remaining <= '0;
      mask_q    <= '0;
      lfsr      <= SEED_DEF;
      last_grp  <= GRP_LAST;
      grp       <= '0;
      timer     <= '0;
      tmo_cnt   <= '0;
      injected  <= '0;
      dropped   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (s_start_i && !s_abort_i) begin
            period_q  <= s_period_i;
            remaining <= s_count_i;
            mask_q    <= s_mask_i;
            lfsr      <= (s_seed_i == '0) ? SEED_DEF : s_seed_i;
            last_grp  <= GRP_LAST;
            injected  <= '0;
            dropped   <= '0;
            tmo_cnt   <= '0;
            if (s_mask_i == '0 || s_count_i == '0) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              timer <= (s_period_i == '0) ? CW'(1) : s_period_i;
            end
          end
        end
        S_WAIT: begin
          if (s_abort_i) begin
            state <= S_DONE;
          end else if (timer == CW'(1)) begin
            state   <= S_REQ;
            grp     <= next_grp;
            tmo_cnt <= '0;
          end else begin
            timer <= timer - CW'(1);
          end
        end
        S_REQ: begin
          if (s_abort_i) begin
            state <= S_DONE;
          end else if (s_ready_i[grp]) begin
            state <= S_FIRE;
          end else if (tmo_hit) begin
            dropped   <= dropped + CW'(1);
            remaining <= remaining - CW'(1);
            last_grp  <= grp;
            tmo_cnt   <= '0;
            if (last_evt) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              timer <= reload;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_FIRE: begin
          // The upset is already on the wire, so it counts even on abort.
          injected  <= injected + CW'(1);
          remaining <= remaining - CW'(1);
          last_grp  <= grp;
          lfsr      <= lfsr_nxt;
          if (s_abort_i || last_evt) begin
            state <= S_DONE;
          end else begin
            state <= S_WAIT;
            timer <= reload;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_req_o = '0;
    if (state == S_REQ) s_req_o[grp] = 1'b1;
  end

  // W is a power of two, so grp*W + bit is the concatenation.
  always_comb begin
    s_upset_o = '0;
    if (state == S_FIRE) s_upset_o[{grp, lfsr[LW-1:0]}] = 1'b1;
  end

  assign s_busy_o     = (state == S_WAIT) || (state == S_REQ) ||
                        (state == S_FIRE);
  assign s_done_o     = (state == S_DONE);
  assign s_injected_o = injected;
  assign s_dropped_o  = dropped;

endmodule
